salamander_rom_loader: RTL

SALAMANDER_ROM_LOADER -- requirements
Module: salamander_rom_loader

---
 rtl/salamander_loader_pkg.sv | 36 +++
 rtl/salamander_loader_decode.sv | 33 +++
 rtl/salamander_rom_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/salamander_loader_pkg.sv
// Shared types and PROM region map for the Salamander ROM loader.
package salamander_loader_pkg;

    localparam int unsigned NUM_REGIONS = 4;
    localparam int unsigned IOCTL_AW    = 25;
    localparam int unsigned REG_IW      = $clog2(NUM_REGIONS);

    localparam logic [7:0] LOADER_INDEX = 8'd0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        HOLD,
        DONE
    } loader_state_e;

    localparam logic [NUM_REGIONS-1:0][IOCTL_AW-1:0] REGION_BASE = {
        25'h020100, 25'h020000, 25'h010000, 25'h000000
    };

    localparam logic [NUM_REGIONS-1:0][IOCTL_AW-1:0] REGION_LEN = {
        25'h000100, 25'h000100, 25'h010000, 25'h010000
    };

    // One bit wider than the address so base + length cannot wrap.
    function automatic logic region_hit(input logic [IOCTL_AW-1:0] addr,
                                        input logic [REG_IW-1:0]   idx);
        logic [IOCTL_AW:0] lo;
        logic [IOCTL_AW:0] hi;
        lo = {1'b0, REGION_BASE[idx]};
        hi = lo + {1'b0, REGION_LEN[idx]};
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

endpackage

// File: rtl/salamander_loader_decode.sv
// Combinational download-address decoder: region hit, one-hot select, region offset.
module salamander_loader_decode
    import salamander_loader_pkg::*;
#(
    parameter int unsigned AW   = 16,
    parameter int unsigned NREG = NUM_REGIONS
) (
    input  logic [IOCTL_AW-1:0] addr_i,
    output logic                hit_c,
    output logic [NREG-1:0]     cs_c,
    output logic [AW-1:0]       offset_c
);

    logic [NREG-1:0]         hit_vec;
    logic [NREG-1:0][AW-1:0] off_vec;

    for (genvar g = 0; g < NREG; g++) begin : g_region
        assign hit_vec[g] = region_hit(addr_i, REG_IW'(g));
        assign off_vec[g] = hit_vec[g] ? AW'(addr_i - REGION_BASE[g]) : '0;
    end

    // Regions are disjoint, so OR-merging the masked offsets selects the hit one.
    always_comb begin
        offset_c = '0;
        for (int i = 0; i < NREG; i++) begin
            offset_c = offset_c | off_vec[i];
        end
    end

    assign cs_c  = hit_vec;
    assign hit_c = |hit_vec;

endmodule

// File: rtl/salamander_rom_loader.sv
// HPS ioctl download to PROM program-bus loader. Optional byte checksum on
// o_CHECKSUM is built only when SALAMANDER_LOADER_CHECKSUM_EN is defined.
module salamander_rom_loader
    import salamander_loader_pkg::*;
#(
    parameter int unsigned AW   = 16,
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 4
) (
    input  logic                i_MCLK,
    input  logic                i_RST_n,
    input  logic                i_IOCTL_DOWNLOAD,
    input  logic [7:0]          i_IOCTL_INDEX,
    input  logic [IOCTL_AW-1:0] i_IOCTL_ADDR,
    input  logic [DW-1:0]       i_IOCTL_DOUT,
    input  logic                i_IOCTL_WR,
    output logic                o_IOCTL_WAIT,
    output logic [AW-1:0]       o_PROG_ADDR,
    output logic [DW-1:0]       o_PROG_DIN,
    output logic                o_PROG_WR,
    output logic [NREG-1:0]     o_PROG_CS,
    output logic                o_ROM_READY,
    output logic                o_OVERRUN,
    output logic [15:0]         o_CHECKSUM
);

    loader_state_e   state_q, state_d;
    logic            dl_prev_q, dl_prev_d;
    logic            armed_q, armed_d;
    logic            fall_pend_q, fall_pend_d;
    logic            wr_q, wr_d;
    logic            ready_q, ready_d;
    logic            overrun_q, overrun_d;
    logic [NREG-1:0] cs_q, cs_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;

    logic            dec_hit;
    logic [NREG-1:0] dec_cs;
    logic [AW-1:0]   dec_offset;

    logic            dl_rise_c;
    logic            dl_fall_c;
    logic            start_c;

    salamander_loader_decode #(
        .AW   (AW),
        .NREG (NREG)
    ) u_decode (
        .addr_i   (i_IOCTL_ADDR),
        .hit_c    (dec_hit),
        .cs_c     (dec_cs),
        .offset_c (dec_offset)
    );

    // A rise only counts once download has been seen low since reset.
    assign dl_rise_c = i_IOCTL_DOWNLOAD && !dl_prev_q && armed_q;
    assign dl_fall_c = !i_IOCTL_DOWNLOAD && dl_prev_q;
    assign start_c   = dl_rise_c && (i_IOCTL_INDEX == LOADER_INDEX)
                       && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d     = state_q;
        dl_prev_d   = i_IOCTL_DOWNLOAD;
        armed_d     = armed_q || !i_IOCTL_DOWNLOAD;
        fall_pend_d = fall_pend_q;
        wr_d        = 1'b0;
        ready_d     = ready_q;
        overrun_d   = overrun_q;
        cs_d        = cs_q;
        addr_d      = addr_q;
        din_d       = din_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_c) begin
                    state_d     = LOAD;
                    ready_d     = 1'b0;
                    overrun_d   = 1'b0;
                    fall_pend_d = 1'b0;
                end
            end
            LOAD: begin
                if (dl_fall_c) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else if (i_IOCTL_WR && dec_hit) begin
                    state_d = WRITE;
                    cs_d    = dec_cs;
                    addr_d  = dec_offset;
                    din_d   = i_IOCTL_DOUT;
                    wr_d    = 1'b1;
                end
            end
            WRITE: begin
                state_d = HOLD;
                if (dl_fall_c)  fall_pend_d = 1'b1;
                if (i_IOCTL_WR) overrun_d   = 1'b1;
            end
            HOLD: begin
                cs_d        = '0;
                fall_pend_d = 1'b0;
                if (i_IOCTL_WR) overrun_d = 1'b1;
                if (fall_pend_q || dl_fall_c) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = '0;
            end
        endcase
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q     <= IDLE;
            dl_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
            fall_pend_q <= 1'b0;
            wr_q        <= 1'b0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            cs_q        <= '0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            dl_prev_q   <= dl_prev_d;
            armed_q     <= armed_d;
            fall_pend_q <= fall_pend_d;
            wr_q        <= wr_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            cs_q        <= cs_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

`ifdef SALAMANDER_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Accumulates the byte being written while the PROM strobe is high.
    always_comb begin
        csum_d = csum_q;
        if (start_c) begin
            csum_d = '0;
        end else if (state_q == WRITE) begin
            csum_d = csum_q + 16'(din_q);
        end
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign o_CHECKSUM = csum_q;
`else
    assign o_CHECKSUM = '0;
`endif

    assign o_IOCTL_WAIT = (state_q == WRITE) || (state_q == HOLD);
    assign o_PROG_ADDR  = addr_q;
    assign o_PROG_DIN   = din_q;
    assign o_PROG_WR    = wr_q;
    assign o_PROG_CS    = cs_q;
    assign o_ROM_READY  = ready_q;
    assign o_OVERRUN    = overrun_q;

endmodule
